// File: rtl/wb_dest_pipe.sv
// rtl/wb_dest_pipe.sv - destination-register delay pipe with per-stage hazard match
// Tracks in-flight register writes so later instructions can detect RAW hazards.
module wb_dest_pipe #(
  parameter int AW        = 3,
  parameter int DEPTH     = 3,
  parameter int LINK_ADDR = 7,
  parameter int ZERO_REG  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             wr_en_in,
  input  logic [1:0]       dst_sel,
  input  logic [AW-1:0]    dst_in1,
  input  logic [AW-1:0]    dst_in2,
  input  logic [AW-1:0]    q_rs,
  input  logic [AW-1:0]    q_rt,
  output logic             out_valid,
  output logic [AW-1:0]    out_dst,
  output logic [DEPTH-1:0] hit_rs,
  output logic [DEPTH-1:0] hit_rt
);

  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0][AW-1:0] dst_q, dst_d;
  logic                     cand_v;
  logic [AW-1:0]            cand_sel, cand_dst;
  logic                     rs_zero, rt_zero;

  always_comb begin
    cand_sel = dst_in1;
    case (dst_sel)
      2'd1:    cand_sel = dst_in2;
      2'd2:    cand_sel = AW'(LINK_ADDR);
      default: cand_sel = dst_in1;
    endcase
  end

  // Bubbles always carry dst=0, so every shifted stage keeps that invariant.
  assign cand_v   = in_valid & wr_en_in;
  assign cand_dst = cand_v ? cand_sel : '0;

  always_comb begin
    v_d   = v_q;
    dst_d = dst_q;
    if (flush) begin
      v_d[0]   = 1'b0;
      dst_d[0] = '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (i == 1) begin
          v_d[i]   = 1'b0;
          dst_d[i] = '0;
        end else begin
          v_d[i]   = v_q[i-1];
          dst_d[i] = dst_q[i-1];
        end
      end
    end else if (!stall) begin
      v_d[0]   = cand_v;
      dst_d[0] = cand_dst;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]   = v_q[i-1];
        dst_d[i] = dst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      dst_q <= '0;
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
    end
  end

  assign rs_zero = (ZERO_REG != 0) && (q_rs == '0);
  assign rt_zero = (ZERO_REG != 0) && (q_rt == '0);

  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs[i] = v_q[i] && (dst_q[i] == q_rs) && !rs_zero;
      hit_rt[i] = v_q[i] && (dst_q[i] == q_rt) && !rt_zero;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_dst   = dst_q[DEPTH-1];

endmodule

// File: tb/tb_wb_dest_pipe.sv
// tb/tb_wb_dest_pipe.sv - scoreboard bench for wb_dest_pipe (DEPTH=3 and DEPTH=1 builds)
module tb_wb_dest_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flush, in_valid, wr_en_in;
  logic [1:0] dst_sel;
  logic [2:0] dst_in1, dst_in2, q_rs, q_rt;
  logic       out_valid;
  logic [2:0] out_dst;
  logic [2:0] hit_rs, hit_rt;

  logic       d1_stall, d1_flush, d1_in_valid, d1_wr_en_in;
  logic [1:0] d1_dst_sel;
  logic [2:0] d1_dst_in1, d1_dst_in2, d1_q_rs, d1_q_rt;
  logic       d1_out_valid;
  logic [2:0] d1_out_dst;
  logic [0:0] d1_hit_rs, d1_hit_rt;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int exp_dst[$], exp_cyc[$];
  int exp1_dst[$], exp1_cyc[$];

  wb_dest_pipe #(.AW(3), .DEPTH(3), .LINK_ADDR(7), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .wr_en_in(wr_en_in), .dst_sel(dst_sel),
    .dst_in1(dst_in1), .dst_in2(dst_in2), .q_rs(q_rs), .q_rt(q_rt),
    .out_valid(out_valid), .out_dst(out_dst), .hit_rs(hit_rs), .hit_rt(hit_rt)
  );

  wb_dest_pipe #(.AW(3), .DEPTH(1), .LINK_ADDR(7), .ZERO_REG(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .stall(d1_stall), .flush(d1_flush),
    .in_valid(d1_in_valid), .wr_en_in(d1_wr_en_in), .dst_sel(d1_dst_sel),
    .dst_in1(d1_dst_in1), .dst_in2(d1_dst_in2), .q_rs(d1_q_rs), .q_rt(d1_q_rt),
    .out_valid(d1_out_valid), .out_dst(d1_out_dst), .hit_rs(d1_hit_rs), .hit_rt(d1_hit_rt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; wr_en_in = 0; stall = 0; flush = 0;
    dst_sel = 0; dst_in1 = 0; dst_in2 = 0;
  endtask

  task automatic cap(input logic [1:0] sel, input logic [2:0] a, input logic [2:0] b);
    in_valid = 1; wr_en_in = 1; dst_sel = sel; dst_in1 = a; dst_in2 = b;
  endtask

  task automatic d1_idle();
    d1_in_valid = 0; d1_wr_en_in = 0; d1_stall = 0; d1_flush = 0;
    d1_dst_sel = 0; d1_dst_in1 = 0; d1_dst_in2 = 0; d1_q_rs = 0; d1_q_rt = 0;
  endtask

  // Monitor for the DEPTH=3 pipe: one pop per presented write; a stalled write is not re-popped.
  initial begin
    logic held;
    int   d, c;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 0;
      else if (out_valid) begin
        if (!held) begin
          if (exp_dst.size() == 0) check("unexpected_write", {29'd0, out_dst}, 32'hFFFF_FFFF);
          else begin
            d = exp_dst.pop_front();
            c = exp_cyc.pop_front();
            check("out_dst", {29'd0, out_dst}, d);
            check("out_cycle", cyc, c);
          end
        end
        held = stall & ~flush;
      end else held = 0;
    end
  end

  initial begin
    logic held;
    int   d, c;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 0;
      else if (d1_out_valid) begin
        if (!held) begin
          if (exp1_dst.size() == 0) check("d1_unexpected_write", {29'd0, d1_out_dst}, 32'hFFFF_FFFF);
          else begin
            d = exp1_dst.pop_front();
            c = exp1_cyc.pop_front();
            check("d1_out_dst", {29'd0, d1_out_dst}, d);
            check("d1_out_cycle", cyc, c);
          end
        end
        held = d1_stall & ~d1_flush;
      end else held = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst_n = 0;
    idle(); q_rs = 0; q_rt = 0;
    d1_idle();
    // Reset holds everything at zero even with a live candidate presented.
    cap(2'd0, 3'd5, 3'd0); q_rs = 5;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dst", out_dst, 0);
    tick(); tick();
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_hit_rs", hit_rs, 0);
    rst_n = 1;
    // First capture happens only on an edge with stall=0.
    stall = 1; cap(2'd0, 3'd4, 3'd0); q_rs = 4;
    tick();
    check("stall_after_rst_hit", hit_rs, 3'b000);
    idle(); tick(); tick(); tick();

    // Basic latency through dst_in2.
    cap(2'd1, 3'd2, 3'd5); q_rs = 5; q_rt = 2;
    tick(); c = cyc;
    exp_dst.push_back(5); exp_cyc.push_back(c + 2);
    check("lat_hit_rs0", hit_rs, 3'b001);
    check("lat_hit_rt0", hit_rt, 3'b000);
    idle(); tick();
    check("lat_hit_rs1", hit_rs, 3'b010);
    tick();
    check("lat_hit_rs2", hit_rs, 3'b100);
    tick();
    check("lat_hit_rs3", hit_rs, 3'b000);

    // Link select followed by two stall cycles; the stalled-in candidate is dropped.
    cap(2'd2, 3'd1, 3'd3); q_rs = 7; q_rt = 6;
    tick(); c = cyc;
    exp_dst.push_back(7); exp_cyc.push_back(c + 4);
    check("link_hit_rs0", hit_rs, 3'b001);
    stall = 1; cap(2'd0, 3'd6, 3'd0);
    tick();
    check("link_stall1_rs", hit_rs, 3'b001);
    check("link_stall1_rt", hit_rt, 3'b000);
    tick();
    check("link_stall2_rs", hit_rs, 3'b001);
    idle(); tick();
    check("link_adv_rs", hit_rs, 3'b010);
    tick(); tick();

    // Flush with stall kills the youngest entry B=4; A=3 keeps moving.
    cap(2'd0, 3'd3, 3'd0);
    tick(); c = cyc;
    exp_dst.push_back(3); exp_cyc.push_back(c + 2);
    cap(2'd3, 3'd4, 3'd0);
    tick();
    flush = 1; stall = 1; cap(2'd0, 3'd5, 3'd0); flush = 1; stall = 1;
    q_rs = 4; q_rt = 3;
    tick();
    check("flush_hit_rs_B", hit_rs, 3'b000);
    check("flush_hit_rt_A", hit_rt, 3'b100);
    idle(); q_rs = 5;
    tick();
    check("flush_no_cand", hit_rs, 3'b000);
    tick(); tick();

    // Zero register never hits but still writes back.
    cap(2'd0, 3'd0, 3'd0); q_rs = 0; q_rt = 0;
    tick(); c = cyc;
    exp_dst.push_back(0); exp_cyc.push_back(c + 2);
    check("zero_hit_rs0", hit_rs, 0);
    check("zero_hit_rt0", hit_rt, 0);
    idle(); tick();
    check("zero_hit_rs1", hit_rs, 0);
    tick();
    check("zero_hit_rt2", hit_rt, 0);
    // in_valid without wr_en_in advances a bubble.
    in_valid = 1; wr_en_in = 0; dst_in1 = 3; q_rs = 3;
    tick();
    check("nowr_bubble", hit_rs, 3'b000);
    idle();
    // Two stages holding the same destination both report a hit.
    cap(2'd0, 3'd6, 3'd0); q_rs = 6;
    tick(); c = cyc;
    exp_dst.push_back(6); exp_cyc.push_back(c + 2);
    tick();
    exp_dst.push_back(6); exp_cyc.push_back(c + 3);
    check("multi_hit_011", hit_rs, 3'b011);
    idle(); tick();
    check("multi_hit_110", hit_rs, 3'b110);
    tick(); tick();

    // Async reset between edges discards three live entries.
    cap(2'd0, 3'd1, 3'd0); tick();
    cap(2'd0, 3'd2, 3'd0); tick();
    cap(2'd0, 3'd3, 3'd0); q_rs = 2; q_rt = 3;
    tick();
    check("pre_rst_hit_rs", hit_rs, 3'b010);
    check("pre_rst_out_valid", out_valid, 1);
    idle();
    #2 rst_n = 0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_dst", out_dst, 0);
    check("async_hit_rs", hit_rs, 0);
    check("async_hit_rt", hit_rt, 0);
    rst_n = 1;
    tick(); tick();
    check("post_rst_valid", out_valid, 0);
    tick();
    check("post_rst_valid2", out_valid, 0);

    // DEPTH=1 build: write visible one cycle; flush with a new capture leaves a bubble.
    d1_in_valid = 1; d1_wr_en_in = 1; d1_dst_sel = 0; d1_dst_in1 = 6; d1_q_rs = 6;
    tick(); c = cyc;
    exp1_dst.push_back(6); exp1_cyc.push_back(c);
    check("d1_hit_rs", d1_hit_rs, 1);
    d1_flush = 1; d1_dst_in1 = 2; d1_q_rs = 2;
    tick();
    check("d1_flush_valid", d1_out_valid, 0);
    check("d1_flush_hit", d1_hit_rs, 0);
    d1_idle(); tick();
    check("d1_idle_valid", d1_out_valid, 0);
    d1_in_valid = 1; d1_wr_en_in = 1; d1_dst_sel = 1; d1_dst_in2 = 1;
    tick(); c = cyc;
    exp1_dst.push_back(1); exp1_cyc.push_back(c);
    d1_stall = 1; d1_dst_in2 = 3;
    tick();
    check("d1_stall_valid", d1_out_valid, 1);
    check("d1_stall_dst", d1_out_dst, 1);
    d1_idle(); tick();
    check("d1_after_stall", d1_out_valid, 0);
    tick(); tick();

    check("exp_q_drained", exp_dst.size(), 0);
    check("exp1_q_drained", exp1_dst.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_dest_pipe.md
WB_DEST_PIPE -- requirements
Module: wb_dest_pipe

Interface
REQ-001 Parameter: AW, default 3, register-address width in bits.
REQ-002 Parameter: DEPTH, default 3, number of delay stages, legal range 1..8.
REQ-003 Parameter: LINK_ADDR, default 7, fixed destination used when dst_sel=2.
REQ-004 Parameter: ZERO_REG, default 1; when 1, address 0 never produces a hazard hit.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 stall  input  1  hold all stages.
REQ-008 flush  input  1  kill the youngest in-flight entry and insert a bubble.
REQ-009 in_valid  input  1  new instruction present this cycle.
REQ-010 wr_en_in  input  1  new instruction writes the register file.
REQ-011 dst_sel  input  2  0=dst_in1, 1=dst_in2, 2=LINK_ADDR, 3=dst_in1.
REQ-012 dst_in1, dst_in2  input  AW  candidate destination addresses.
REQ-013 q_rs, q_rt  input  AW  source addresses for hazard query.
REQ-014 out_valid  output  1  stage DEPTH-1 holds a live write.
REQ-015 out_dst  output  AW  destination address to the register file.
REQ-016 hit_rs, hit_rt  output  DEPTH  per-stage match vectors; bit i is stage i.

Function
REQ-017 Each stage SHALL be a register pair {v, dst}.
REQ-018 Select: the stage-0 candidate address SHALL be chosen by dst_sel per REQ-011.
REQ-019 Candidate valid SHALL equal in_valid & wr_en_in.
REQ-020 Bubble: any stage loaded with v=0 SHALL also load dst=0.
REQ-021 Advance (stall=0, flush=0): stage[i] loads stage[i-1] for i>=1, and stage 0 loads the candidate.
REQ-022 Hold (stall=1, flush=0): all stages SHALL retain their contents, and the candidate SHALL be dropped.
REQ-023 Flush (flush=1, either stall value): stall is overridden, and stage 0 loads a bubble.
REQ-024 Flush, DEPTH>=2: stage 1 loads a bubble (the old stage-0 entry is killed), and stages i>=2 load stage[i-1].
REQ-025 Flush, DEPTH=1: only the stage-0 bubble load applies.
REQ-026 out_valid SHALL be stage[DEPTH-1].v and out_dst SHALL be stage[DEPTH-1].dst, driven directly from the registers.
REQ-027 Latency: an uninterrupted entry SHALL appear on out_* exactly DEPTH rising edges after capture; each stall cycle adds 1.
REQ-028 hit_rs[i] SHALL equal stage[i].v & (stage[i].dst==q_rs) & !(ZERO_REG & q_rs==0); hit_rt is the same using q_rt.
REQ-029 hit_rs and hit_rt SHALL be combinational from current state and queries, with no dependence on stall or flush.
REQ-030 Multiple stages matching the same address SHALL all assert their hit bits; priority is left to the consumer.
REQ-031 in_valid=1 with wr_en_in=0 SHALL advance a bubble.

Reset
REQ-032 rst_n=0 SHALL clear every stage v and dst to 0 immediately, without waiting for clk.
REQ-033 While rst_n=0: out_valid=0, out_dst=0, hit_rs=0, hit_rt=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-035 After rst_n rises, the first capture SHALL occur on the first rising edge with stall=0.

Verification
REQ-036 Basic latency: AW=3, DEPTH=3; cycle 0 in_valid=1, wr_en_in=1, dst_sel=1, dst_in2=5, stall=0; then idle. -> out_valid=1 with out_dst=5 after the 3rd edge only; hit_rs=3'b001, 3'b010, 3'b100 on successive cycles with q_rs=5.
REQ-037 Link select with stall: dst_sel=2 captured, then stall=1 for 2 cycles. -> out_dst=7 appears after 5 edges, and the stage contents are unchanged during the stall.
REQ-038 Flush: entries A=3 then B=4 captured, flush=1 on the next cycle with stall=1. -> B is killed, A reaches out_dst=3, and no out_valid occurs for B.
REQ-039 Zero register: capture dst=0 with q_rs=0, q_rt=0. -> hit_rs=hit_rt=0 throughout, and out_valid=1 with out_dst=0 still occurs.
REQ-040 Async reset: 3 live entries in flight, rst_n pulsed low between edges. -> out_valid, out_dst and hits are 0 before the next edge, and no stale write emerges afterwards.
REQ-041 DEPTH=1 build: capture dst=6, with flush on the same cycle as a new capture of dst=2. -> out_dst=6 for one cycle, then out_valid=0.
